// File: rtl/adc_trigger_unit.sv
// adc_trigger_unit: trigger sequencer in the ADC sample-clock domain.
// It watches a synchronised trigger pin, or a forced trigger, and waits a
// programmed offset after the detect. It then emits a one-cycle capture_go
// and measures how long the trigger stayed active.
// Optional feature macro: TRIG_LEVEL_EN adds an ADC level comparator that can
// act as the trigger source instead of the pin.
module adc_trigger_unit #(
  parameter int pOFFSET_W = 32,
  parameter int pLEN_W    = 32,
  parameter int pADC_W    = 12
) (
  input  logic                 adc_sampleclk,
  input  logic                 reset_i,
  input  logic                 cmd_arm_adc,
  input  logic                 trigger_mode,
  input  logic                 trigger_wait,
  input  logic                 trigger_now,
  input  logic [pOFFSET_W-1:0] trigger_offset,
  input  logic                 trigger_io,
  input  logic [pADC_W-1:0]    adc_data,
  input  logic [pADC_W-1:0]    trigger_adclevel,
  input  logic                 level_trig_sel,
  output logic                 armed_o,
  output logic                 capture_go,
  output logic [pLEN_W-1:0]    trigger_length
);

  typedef enum logic [2:0] {
    IDLE, WAIT_INACTIVE, ARMED, OFFSET, FIRE, DONE
  } state_t;

  state_t state, state_nxt;

  logic io_m, io_s, now_m, now_s;
  logic trig_p, arm_p, counting, load_cnt;
  logic src, use_pin, trig_s, edge_det, detect, pin_det, arm_rise;
  logic start_len, clear_len;
  logic [pOFFSET_W-1:0] cnt;

  // Two-flop synchronisers for the asynchronous pin and force-trigger inputs
  always_ff @(posedge adc_sampleclk or posedge reset_i) begin
    if (reset_i) begin
      io_m  <= 1'b0;
      io_s  <= 1'b0;
      now_m <= 1'b0;
      now_s <= 1'b0;
    end else begin
      io_m  <= trigger_io;
      io_s  <= io_m;
      now_m <= trigger_now;
      now_s <= now_m;
    end
  end

`ifdef TRIG_LEVEL_EN
  logic lvl_r;

  // The ADC data is already in this clock domain, so one register stage is enough
  always_ff @(posedge adc_sampleclk or posedge reset_i) begin
    if (reset_i) lvl_r <= 1'b0;
    else         lvl_r <= (adc_data >= trigger_adclevel);
  end

  assign src     = level_trig_sel ? lvl_r : io_s;
  assign use_pin = ~level_trig_sel;
`else
  logic unused_level;
  assign unused_level = ^{adc_data, trigger_adclevel, level_trig_sel};
  assign src     = io_s;
  assign use_pin = 1'b1;
`endif

  // Active-level form of the source: 1 means the trigger is active for the selected polarity
  assign trig_s    = ~(src ^ trigger_mode);
  assign edge_det  = trig_s & ~trig_p;
  assign detect    = edge_det | now_s;
  // Only genuine pin edges start the length measurement
  assign pin_det   = edge_det & ~now_s & use_pin;
  assign arm_rise  = cmd_arm_adc & ~arm_p;
  assign start_len = (state == ARMED) & cmd_arm_adc & pin_det;
  assign clear_len = (state == IDLE) & arm_rise;
  assign armed_o   = (state == WAIT_INACTIVE) | (state == ARMED) | (state == OFFSET);

  // Edge-history flops for the trigger level and the arm level
  always_ff @(posedge adc_sampleclk or posedge reset_i) begin
    if (reset_i) begin
      trig_p <= 1'b0;
      arm_p  <= 1'b0;
    end else begin
      trig_p <= trig_s;
      arm_p  <= cmd_arm_adc;
    end
  end

  // State register
  always_ff @(posedge adc_sampleclk or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic. Dropping arm overrides everything, including a detect in the same cycle
  always_comb begin
    state_nxt = state;
    load_cnt  = 1'b0;
    if (!cmd_arm_adc) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:          if (arm_rise) state_nxt = trigger_wait ? WAIT_INACTIVE : ARMED;
        WAIT_INACTIVE: if (!trig_s) state_nxt = ARMED;
        ARMED: begin
          if (detect) begin
            load_cnt  = 1'b1;
            state_nxt = (trigger_offset == '0) ? FIRE : OFFSET;
          end
        end
        OFFSET:        if (cnt == pOFFSET_W'(1)) state_nxt = FIRE;
        FIRE:          state_nxt = DONE;
        DONE:          state_nxt = DONE;
        default:       state_nxt = IDLE;
      endcase
    end
  end

  // Offset down-counter. The offset is captured at detect, so later writes do not disturb it
  always_ff @(posedge adc_sampleclk or posedge reset_i) begin
    if (reset_i)                cnt <= '0;
    else if (load_cnt)          cnt <= trigger_offset;
    else if (state == OFFSET)   cnt <= cnt - pOFFSET_W'(1);
  end

  // Registered capture pulse. It is suppressed if arm drops while in FIRE
  always_ff @(posedge adc_sampleclk or posedge reset_i) begin
    if (reset_i) capture_go <= 1'b0;
    else         capture_go <= (state == FIRE) & cmd_arm_adc;
  end

  // Trigger-active duration: starts at 1 on the detect cycle and saturates.
  // The count stops at the first inactive cycle and is held until the next arm.
  always_ff @(posedge adc_sampleclk or posedge reset_i) begin
    if (reset_i) begin
      trigger_length <= '0;
      counting       <= 1'b0;
    end else if (clear_len) begin
      trigger_length <= '0;
      counting       <= 1'b0;
    end else if (start_len) begin
      trigger_length <= pLEN_W'(1);
      counting       <= 1'b1;
    end else if (counting) begin
      if (!trig_s)                    counting       <= 1'b0;
      else if (trigger_length != '1)  trigger_length <= trigger_length + pLEN_W'(1);
    end
  end

endmodule
